// File: rtl/r5p_soc_ctl.sv
// System controller slave on the r5p load/store bus: signature window, halt/exit code,
// cycle counter, watchdog and byte console. Console FIFO enabled by R5P_SOC_CTL_CONSOLE_EN.
module r5p_soc_ctl #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6,
  parameter int unsigned CW = 32,
  parameter int unsigned FD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_vld,
  input  logic            bus_wen,
  input  logic [AW-1:0]   bus_adr,
  input  logic [DW/8-1:0] bus_ben,
  input  logic [DW-1:0]   bus_wdt,
  output logic [DW-1:0]   bus_rdt,
  output logic            bus_rdy,
  output logic [DW-1:0]   sig_begin,
  output logic [DW-1:0]   sig_end,
  output logic            halt,
  output logic [DW-2:0]   exit_code,
  output logic            timeout,
  output logic            con_vld,
  output logic [7:0]      con_dat,
  input  logic            con_rdy
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = AW - 3;
  localparam int unsigned PW = $clog2(FD);

  logic [IW-1:0] idx;
  logic sel_sb, sel_se, sel_halt, sel_tlim, sel_cyc, sel_con, sel_stat;
  logic hs, wr_hs, rd_hs;
  logic fifo_full, fifo_empty;
  logic [PW:0] fifo_cnt;

  logic [DW-1:0] rdt_q, rdt_d, sig_begin_q, sig_begin_d, sig_end_q, sig_end_d;
  logic          halt_q, halt_d, timeout_q, timeout_d;
  logic [DW-2:0] exit_code_q, exit_code_d;
  logic [CW-1:0] tlimit_q, tlimit_d, cycle_q, cycle_d;
  logic          cyc_hit;
  logic [DW-1:0] status;

  function automatic logic [DW-1:0] be_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [BW-1:0] be);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign idx      = bus_adr[AW-1:3];
  assign sel_sb   = (idx == IW'(0));
  assign sel_se   = (idx == IW'(1));
  assign sel_halt = (idx == IW'(2));
  assign sel_tlim = (idx == IW'(3));
  assign sel_cyc  = (idx == IW'(4));
  assign sel_con  = (idx == IW'(5));
  assign sel_stat = (idx == IW'(6));

  // Stall depends only on registered FIFO state, never on con_rdy.
  assign bus_rdy = !(bus_vld && bus_wen && sel_con && fifo_full);
  assign hs      = bus_vld && bus_rdy;
  assign wr_hs   = hs && bus_wen;
  assign rd_hs   = hs && !bus_wen;

  always_comb begin
    status        = '0;
    status[0]     = halt_q;
    status[1]     = timeout_q;
    status[2]     = fifo_full;
    status[3]     = fifo_empty;
    status[15:8]  = 8'(fifo_cnt);

    sig_begin_d   = sig_begin_q;
    sig_end_d     = sig_end_q;
    halt_d        = halt_q;
    exit_code_d   = exit_code_q;
    tlimit_d      = tlimit_q;
    rdt_d         = rdt_q;

    // Counter stops on the matching cycle so it holds the limit value after expiry.
    cyc_hit   = (tlimit_q != '0) && (cycle_q == tlimit_q);
    timeout_d = timeout_q || cyc_hit;
    cycle_d   = cycle_q;
    if (!halt_q && !timeout_q && !cyc_hit) cycle_d = cycle_q + CW'(1);

    if (wr_hs) begin
      if (sel_sb) sig_begin_d = be_merge(sig_begin_q, bus_wdt, bus_ben);
      if (sel_se) sig_end_d = be_merge(sig_end_q, bus_wdt, bus_ben);
      if (sel_tlim) tlimit_d = CW'(be_merge(DW'(tlimit_q), bus_wdt, bus_ben));
      if (sel_halt && bus_ben[0] && bus_wdt[0] && !halt_q) begin
        halt_d      = 1'b1;
        exit_code_d = bus_wdt[DW-1:1];
      end
    end

    if (rd_hs) begin
      rdt_d = '0;
      if (sel_sb)   rdt_d = sig_begin_q;
      if (sel_se)   rdt_d = sig_end_q;
      if (sel_tlim) rdt_d = DW'(tlimit_q);
      if (sel_cyc)  rdt_d = DW'(cycle_q);
      if (sel_stat) rdt_d = status;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdt_q       <= '0;
      sig_begin_q <= '0;
      sig_end_q   <= '0;
      halt_q      <= 1'b0;
      exit_code_q <= '0;
      timeout_q   <= 1'b0;
      tlimit_q    <= '0;
      cycle_q     <= '0;
    end else begin
      rdt_q       <= rdt_d;
      sig_begin_q <= sig_begin_d;
      sig_end_q   <= sig_end_d;
      halt_q      <= halt_d;
      exit_code_q <= exit_code_d;
      timeout_q   <= timeout_d;
      tlimit_q    <= tlimit_d;
      cycle_q     <= cycle_d;
    end
  end

  assign bus_rdt   = rdt_q;
  assign sig_begin = sig_begin_q;
  assign sig_end   = sig_end_q;
  assign halt      = halt_q;
  assign exit_code = exit_code_q;
  assign timeout   = timeout_q;

`ifdef R5P_SOC_CTL_CONSOLE_EN
  logic [7:0]    mem_q [FD];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push, pop;

  assign push       = wr_hs && sel_con && bus_ben[0];
  assign pop        = !fifo_empty && con_rdy;
  assign fifo_cnt   = cnt_q;
  assign fifo_full  = (cnt_q == (PW+1)'(FD));
  assign fifo_empty = (cnt_q == '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + (PW+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus_wdt[7:0];
  end

  assign con_vld = !fifo_empty;
  assign con_dat = fifo_empty ? 8'h00 : mem_q[rptr_q];
`else
  logic unused_con_rdy;
  assign unused_con_rdy = con_rdy;
  assign fifo_cnt       = '0;
  assign fifo_full      = 1'b0;
  assign fifo_empty     = 1'b1;
  assign con_vld        = 1'b0;
  assign con_dat        = 8'h00;
`endif

  logic unused_adr_lsb;
  assign unused_adr_lsb = ^bus_adr[2:0];

endmodule

// File: tb/tb_r5p_soc_ctl.sv
// Directed self-checking bench for r5p_soc_ctl; console checks follow R5P_SOC_CTL_CONSOLE_EN.
module tb_r5p_soc_ctl;

  logic        clk, rst;
  logic        bus_vld, bus_wen;
  logic [5:0]  bus_adr;
  logic [3:0]  bus_ben;
  logic [31:0] bus_wdt, bus_rdt;
  logic        bus_rdy;
  logic [31:0] sig_begin, sig_end;
  logic        halt, timeout;
  logic [30:0] exit_code;
  logic        con_vld, con_rdy;
  logic [7:0]  con_dat;

  int n_vec = 0;
  int n_err = 0;
  int tb_cyc;

  r5p_soc_ctl #(.DW(32), .AW(6), .CW(32), .FD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_vld   (bus_vld),
    .bus_wen   (bus_wen),
    .bus_adr   (bus_adr),
    .bus_ben   (bus_ben),
    .bus_wdt   (bus_wdt),
    .bus_rdt   (bus_rdt),
    .bus_rdy   (bus_rdy),
    .sig_begin (sig_begin),
    .sig_end   (sig_end),
    .halt      (halt),
    .exit_code (exit_code),
    .timeout   (timeout),
    .con_vld   (con_vld),
    .con_dat   (con_dat),
    .con_rdy   (con_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cyc <= 0;
    else      tb_cyc <= tb_cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus_vld = 1'b0;
    con_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] b,
                    output int waits);
    @(negedge clk);
    bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = a; bus_wdt = d; bus_ben = b;
    waits = 0;
    #1;
    while (!bus_rdy && waits < 200) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 200) chk("wr_bound", 64'(waits), 64'd0);
    @(posedge clk); #1;
    bus_vld = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_vld = 1'b1; bus_wen = 1'b0; bus_adr = a; bus_ben = 4'h0;
    @(posedge clk); #1;
    bus_vld = 1'b0;
    d = bus_rdt;
  endtask

  initial begin
    logic [31:0] v, v2;
    int w, n;
    rst = 1'b0; bus_vld = 1'b0; bus_wen = 1'b0; bus_adr = '0; bus_ben = '0;
    bus_wdt = '0; con_rdy = 1'b0;
    do_reset();

    // Reset state
    #1;
    chk("rst_rdt", bus_rdt, 0);
    chk("rst_sig_begin", sig_begin, 0);
    chk("rst_sig_end", sig_end, 0);
    chk("rst_halt", halt, 0);
    chk("rst_exit", exit_code, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_con_vld", con_vld, 0);
    chk("rst_con_dat", con_dat, 0);
    rd(6'h00, v); chk("rd_sig_begin0", v, 0);
    rd(6'h08, v); chk("rd_sig_end0", v, 0);
    rd(6'h18, v); chk("rd_tlimit0", v, 0);
    rd(6'h30, v); chk("rd_status0", v, 32'h0000_0008);
    rd(6'h38, v); chk("rd_unmapped", v, 0);
    repeat (7) @(posedge clk);
    rd(6'h20, v); chk("rd_cycle", v, 32'(tb_cyc - 1));

    // Byte-enabled signature writes
    wr(6'h00, 32'h1000_0200, 4'b0011, w);
    chk("sig_begin_ben", sig_begin, 32'h0000_0200);
    wr(6'h08, 32'h1000_021C, 4'b1111, w);
    chk("sig_end_full", sig_end, 32'h1000_021C);
    rd(6'h04, v); chk("rd_sig_begin_lsb_ignored", v, 32'h0000_0200);

    // Watchdog disabled
    wr(6'h18, 32'h0, 4'hF, w);
    repeat (1000) @(posedge clk);
    #1 chk("wdog_off", timeout, 0);

    // Watchdog expiry
    do_reset();
    wr(6'h18, 32'd100, 4'hF, w);
    rd(6'h18, v); chk("rd_tlimit", v, 100);
    n = 0;
    while (!timeout && n < 300) begin @(posedge clk); #1; n++; end
    chk("timeout_rise", timeout, 1);
    rd(6'h20, v); chk("cycle_at_limit", v, 100);
    repeat (10) @(posedge clk);
    rd(6'h20, v); chk("cycle_held", v, 100);
    rd(6'h30, v); chk("status_timeout", v, 32'h0000_000A);

    // Halt
    do_reset();
    wr(6'h10, 32'h0000_0054, 4'hF, w);
    chk("halt_bit0_clear", halt, 0);
    wr(6'h10, 32'h0000_0055, 4'hF, w);
    chk("halt_set", halt, 1);
    chk("exit_code", exit_code, 31'h2A);
    wr(6'h10, 32'h0000_0003, 4'hF, w);
    chk("exit_code_frozen", exit_code, 31'h2A);
    rd(6'h20, v);
    repeat (5) @(posedge clk);
    rd(6'h20, v2); chk("cycle_frozen", v2, v);
    rd(6'h30, v); chk("status_halt", v, 32'h0000_0009);
    wr(6'h08, 32'h0000_0ABC, 4'hF, w);
    chk("sig_end_after_halt", sig_end, 32'h0000_0ABC);

`ifdef R5P_SOC_CTL_CONSOLE_EN
    // Fill, stall, single pop releasing the stall, then drain
    do_reset();
    for (int i = 0; i < 16; i++) wr(6'h28, 32'(8'h41 + i), 4'b0001, w);
    rd(6'h30, v); chk("status_full", v, 32'h0000_1004);
    chk("con_vld_full", con_vld, 1);
    chk("con_dat_head", con_dat, 8'h41);
    @(negedge clk);
    bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = 6'h28; bus_wdt = 32'h51; bus_ben = 4'b0001;
    #1 chk("stall_rdy0", bus_rdy, 0);
    repeat (3) @(negedge clk);
    #1 chk("stall_held", bus_rdy, 0);
    con_rdy = 1'b1;
    #1 chk("pop_dat", con_dat, 8'h41);
    @(posedge clk); #1;
    con_rdy = 1'b0;
    chk("rdy_after_pop", bus_rdy, 1);
    @(posedge clk); #1;
    bus_vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      con_rdy = 1'b1;
      #1 chk($sformatf("drain%0d", i), con_dat, 64'(8'h42 + i));
    end
    @(negedge clk);
    con_rdy = 1'b0;
    #1 chk("drained_vld", con_vld, 0);

    // Reset during stalled write
    for (int i = 0; i < 16; i++) wr(6'h28, 32'(i), 4'b0001, w);
    @(negedge clk);
    bus_vld = 1'b1; bus_wen = 1'b1; bus_adr = 6'h28; bus_wdt = 32'h77; bus_ben = 4'b0001;
    #1 chk("stall2_rdy0", bus_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall_vld", con_vld, 0);
    chk("rst_stall_rdy", bus_rdy, 1);
    bus_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd(6'h30, v); chk("rst_stall_status", v, 32'h0000_0008);
`else
    // Console disabled: writes never stall and are discarded
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      wr(6'h28, 32'(8'h41 + i), 4'b0001, w);
      n += w;
    end
    chk("no_stall", 64'(n), 0);
    chk("dis_con_vld", con_vld, 0);
    chk("dis_con_dat", con_dat, 0);
    rd(6'h30, v); chk("dis_status", v, 32'h0000_0008);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
